// File: rtl/rv_pkg.sv
// Shared write-back definitions: default datapath widths and the write-back entry layout.
package rv_pkg;

   localparam int RV_XLEN = 32;
   localparam int RV_AW   = 5;

   // Entry field widths track the package defaults; override XLEN/AW together with these.
   typedef struct packed {
      logic               vld;
      logic               pend;
      logic [RV_AW-1:0]   a;
      logic [RV_XLEN-1:0] d;
   } wb_ent_t;

endpackage

// File: rtl/wb_fwd_port.sv
// One forwarding read port: youngest matching entry wins, with same-cycle load-return bypass.
module wb_fwd_port
   import rv_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int XLEN  = RV_XLEN,
   parameter int AW    = RV_AW
) (
   input  wb_ent_t                      ent [DEPTH],
   input  logic [AW-1:0]                rp_a,
   input  logic [XLEN-1:0]              rp_rf,
   input  logic                         fill_vld,
   input  logic [$clog2(DEPTH)-1:0]     fill_idx,
   input  logic [XLEN-1:0]              lsu_rd,
   output logic [XLEN-1:0]              rp_d,
   output logic                         rp_hz
);

   localparam int IW = $clog2(DEPTH);

   logic          hit;
   wb_ent_t       sel;
   logic [IW-1:0] sel_idx;

   always_comb begin
      hit     = 1'b0;
      sel     = '0;
      sel_idx = '0;
      // Scan oldest to youngest so the youngest match is the last one kept.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ent[i].vld && ent[i].a == rp_a) begin
            hit     = 1'b1;
            sel     = ent[i];
            sel_idx = IW'(i);
         end
      end

      rp_d  = rp_rf;
      rp_hz = 1'b0;
      if (rp_a == '0) begin
         rp_d = '0;
      end else if (hit) begin
         if (!sel.pend)
            rp_d = sel.d;
         else if (fill_vld && fill_idx == sel_idx)
            rp_d = lsu_rd;
         else
            rp_hz = 1'b1;
      end
   end

endmodule

// File: rtl/wb_fwd_buf.sv
// Write-back forwarding buffer: a DEPTH-entry shift pipe that retires into the register file,
// waits at the tail for pending load data, and forwards the youngest result to NRP read ports.
module wb_fwd_buf
   import rv_pkg::*;
#(
   parameter int XLEN  = RV_XLEN,
   parameter int DEPTH = 3,
   parameter int NRP   = 2,
   parameter int AW    = RV_AW
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      flush,
   input  logic                      stall,
   input  logic                      ins_vld,
   input  logic                      ins_ld,
   input  logic [AW-1:0]             ins_rd_a,
   input  logic [XLEN-1:0]           ins_d,
   output logic                      ins_rdy,
   output logic                      hold_o,
   input  logic                      lsu_vld,
   input  logic [XLEN-1:0]           lsu_rd,
   output logic                      lsu_err,
   input  logic [NRP-1:0][AW-1:0]    rp_a,
   input  logic [NRP-1:0][XLEN-1:0]  rp_rf,
   output logic [NRP-1:0][XLEN-1:0]  rp_d,
   output logic [NRP-1:0]            rp_hz,
   output logic                      rf_we,
   output logic [AW-1:0]             rf_a,
   output logic [XLEN-1:0]           rf_d
);

   localparam int IW = $clog2(DEPTH);

   wb_ent_t       ent    [DEPTH];
   wb_ent_t       ent_nx [DEPTH];
   wb_ent_t       cand;
   logic          adv;
   logic          any_pend;
   logic          fill_vld;
   logic [IW-1:0] fill_idx;

   assign hold_o  = ent[DEPTH-1].vld & ent[DEPTH-1].pend;
   assign adv     = ~stall & ~hold_o;
   assign ins_rdy = adv & ~flush;
   assign rf_we   = adv & ent[DEPTH-1].vld & ~ent[DEPTH-1].pend;
   assign rf_a    = ent[DEPTH-1].a;
   assign rf_d    = ent[DEPTH-1].d;

   // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
   always_comb begin
      any_pend = 1'b0;
      fill_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent[i].vld && ent[i].pend) begin
            any_pend = 1'b1;
            fill_idx = IW'(i);
         end
      end
   end

   assign fill_vld = lsu_vld & any_pend;

   always_comb begin
      cand = '0;
      if (ins_vld && !flush && ins_rd_a != '0) begin
         cand.vld  = 1'b1;
         cand.pend = ins_ld;
         cand.a    = ins_rd_a;
         cand.d    = ins_ld ? '0 : ins_d;
      end
   end

   // Fill first, then shift: the returning load lands wherever its entry ends up.
   always_comb begin
      ent_nx = ent;
      if (fill_vld) begin
         ent_nx[fill_idx].pend = 1'b0;
         ent_nx[fill_idx].d    = lsu_rd;
      end
      if (adv) begin
         for (int i = DEPTH - 1; i > 0; i--)
            ent_nx[i] = ent_nx[i-1];
         ent_nx[0] = cand;
      end
   end

   // NOTE: the entries are plain flops rather than a RAM, so they can all take the async clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ent     <= '{default: '0};
         lsu_err <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         ent     <= ent_nx;
         lsu_err <= lsu_vld & ~any_pend;
      end
   end

   for (genvar p = 0; p < NRP; p++) begin : g_port
      wb_fwd_port #(
         .DEPTH (DEPTH),
         .XLEN  (XLEN),
         .AW    (AW)
      ) u_port (
         .ent      (ent),
         .rp_a     (rp_a[p]),
         .rp_rf    (rp_rf[p]),
         .fill_vld (fill_vld),
         .fill_idx (fill_idx),
         .lsu_rd   (lsu_rd),
         .rp_d     (rp_d[p]),
         .rp_hz    (rp_hz[p])
      );
   end

endmodule

// File: tb/tb_wb_fwd_buf.sv
// Self-checking bench for wb_fwd_buf: queue-based reference pipe plus a retire scoreboard.
module tb_wb_fwd_buf;

   localparam int XLEN  = 32;
   localparam int DEPTH = 3;
   localparam int NRP   = 2;
   localparam int AW    = 5;

   logic                     clk;
   logic                     rstn;
   logic                     flush;
   logic                     stall;
   logic                     ins_vld;
   logic                     ins_ld;
   logic [AW-1:0]            ins_rd_a;
   logic [XLEN-1:0]          ins_d;
   logic                     ins_rdy;
   logic                     hold_o;
   logic                     lsu_vld;
   logic [XLEN-1:0]          lsu_rd;
   logic                     lsu_err;
   logic [NRP-1:0][AW-1:0]   rp_a;
   logic [NRP-1:0][XLEN-1:0] rp_rf;
   logic [NRP-1:0][XLEN-1:0] rp_d;
   logic [NRP-1:0]           rp_hz;
   logic                     rf_we;
   logic [AW-1:0]            rf_a;
   logic [XLEN-1:0]          rf_d;

   wb_fwd_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .NRP(NRP), .AW(AW)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .flush    (flush),
      .stall    (stall),
      .ins_vld  (ins_vld),
      .ins_ld   (ins_ld),
      .ins_rd_a (ins_rd_a),
      .ins_d    (ins_d),
      .ins_rdy  (ins_rdy),
      .hold_o   (hold_o),
      .lsu_vld  (lsu_vld),
      .lsu_rd   (lsu_rd),
      .lsu_err  (lsu_err),
      .rp_a     (rp_a),
      .rp_rf    (rp_rf),
      .rp_d     (rp_d),
      .rp_hz    (rp_hz),
      .rf_we    (rf_we),
      .rf_a     (rf_a),
      .rf_d     (rf_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference pipe: front = youngest. lv is the value the load will eventually return.
   typedef struct {
      bit          vld;
      bit          pend;
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] lv;
   } mslot_t;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   mslot_t      pipe[$];
   wr_t         exp_wr[$];
   bit          m_err;
   logic [31:0] cur_lv;
   int          n_checks;
   int          n_errors;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   function automatic int oldest_pend();
      for (int i = DEPTH - 1; i >= 0; i--)
         if (pipe[i].vld && pipe[i].pend) return i;
      return -1;
   endfunction

   task automatic model_clear();
      mslot_t z;
      z = '{default: 0};
      pipe.delete();
      for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
      exp_wr.delete();
      m_err = 1'b0;
   endtask

   // One cycle: check outputs against the model mid-cycle, then advance the model.
   task automatic tick();
      mslot_t      tail;
      mslot_t      cand;
      int          f;
      int          s;
      bit          m_adv;
      logic [31:0] ed;
      bit          eh;
      if (!rstn) model_clear();
      @(negedge clk);
      tail  = pipe[DEPTH-1];
      m_adv = !stall && !(tail.vld && tail.pend);
      check("ins_rdy", 32'(ins_rdy), 32'(m_adv && !flush));
      check("hold_o",  32'(hold_o),  32'(tail.vld && tail.pend));
      check("lsu_err", 32'(lsu_err), 32'(m_err));
      check("rf_we",   32'(rf_we),   32'(m_adv && tail.vld && !tail.pend));
      check("rf_a",    32'(rf_a),    32'(tail.a));
      check("rf_d",    rf_d,         tail.d);
      f = oldest_pend();
      for (int p = 0; p < NRP; p++) begin
         s = -1;
         for (int i = 0; i < DEPTH; i++)
            if (s < 0 && pipe[i].vld && pipe[i].a == rp_a[p]) s = i;
         eh = 1'b0;
         if (rp_a[p] == 0)                       ed = 0;
         else if (s < 0)                         ed = rp_rf[p];
         else if (!pipe[s].pend)                 ed = pipe[s].d;
         else if (lsu_vld && s == f)             ed = lsu_rd;
         else begin ed = rp_rf[p]; eh = 1'b1; end
         check($sformatf("rp_d[%0d]", p),  rp_d[p],         ed);
         check($sformatf("rp_hz[%0d]", p), 32'(rp_hz[p]),   32'(eh));
      end
      if (rstn) begin
         m_err = lsu_vld && f < 0;
         if (lsu_vld && f >= 0) begin
            pipe[f].pend = 1'b0;
            pipe[f].d    = lsu_rd;
         end
         if (m_adv) begin
            cand = '{default: 0};
            if (ins_vld && !flush && ins_rd_a != 0) begin
               cand.vld  = 1'b1;
               cand.pend = ins_ld;
               cand.a    = ins_rd_a;
               cand.d    = ins_ld ? 32'd0 : ins_d;
               cand.lv   = cur_lv;
               exp_wr.push_back('{ins_rd_a, ins_ld ? cur_lv : ins_d});
            end
            pipe.push_front(cand);
            void'(pipe.pop_back());
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit ld, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] lv, input bit fl, input bit st, input bit lsu,
                        input logic [4:0] r0, input logic [4:0] r1);
      int f;
      f        = oldest_pend();
      ins_vld  = v;
      ins_ld   = ld;
      ins_rd_a = a;
      ins_d    = d;
      cur_lv   = lv;
      flush    = fl;
      stall    = st;
      lsu_vld  = lsu;
      lsu_rd   = (lsu && f >= 0) ? pipe[f].lv : $urandom();
      rp_a[0]  = r0;
      rp_a[1]  = r1;
      rp_rf[0] = $urandom();
      rp_rf[1] = $urandom();
      tick();
   endtask

   task automatic idle(input int n, input logic [4:0] r0, input logic [4:0] r1);
      repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
   endtask

   // Retire scoreboard: every register-file write must match the next accepted instruction.
   initial begin
      wr_t w;
      forever begin
         @(negedge clk);
         if (rf_we === 1'b1) begin
            check("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
            if (exp_wr.size() > 0) begin
               w = exp_wr.pop_front();
               check("wr_a", 32'(rf_a), 32'(w.a));
               check("wr_d", rf_d, w.d);
            end
         end
      end
   end

   initial begin
      int  f;
      bit  lsu;
      n_checks = 0;
      n_errors = 0;
      rstn     = 1'b0;
      flush    = 0; stall = 0; ins_vld = 0; ins_ld = 0; ins_rd_a = 0; ins_d = 0;
      lsu_vld  = 0; lsu_rd = 0; rp_a = '0; rp_rf = '0; cur_lv = 0;
      model_clear();
      idle(2, 5'd1, 5'd0);
      rstn = 1'b1;
      idle(1, 5'd1, 5'd2);

      // Youngest match wins; both writes retire in order.
      drive(1, 0, 5'd5, 32'h11, 0, 0, 0, 0, 5'd5, 5'd0);
      drive(1, 0, 5'd5, 32'h22, 0, 0, 0, 0, 5'd5, 5'd0);
      idle(5, 5'd5, 5'd6);

      // Pending load hazard, then same-cycle bypass.
      drive(1, 1, 5'd7, 32'h0, 32'hDEAD, 0, 0, 0, 5'd7, 5'd7);
      drive(0, 0, 5'd0, 32'h0, 0, 0, 0, 0, 5'd7, 5'd0);
      drive(0, 0, 5'd0, 32'h0, 0, 0, 0, 1, 5'd7, 5'd7);
      idle(4, 5'd7, 5'd0);

      // Load reaches the tail with no return: hold, then release.
      drive(1, 1, 5'd3, 32'h0, 32'h5, 0, 0, 0, 5'd3, 5'd0);
      repeat (4) drive(1, 0, 5'd8, 32'h88, 0, 0, 0, 0, 5'd3, 5'd8);
      drive(0, 0, 5'd0, 32'h0, 0, 0, 0, 1, 5'd3, 5'd0);
      idle(5, 5'd3, 5'd8);

      // Flushed insert and rd=0 insert both become bubbles.
      drive(1, 0, 5'd9, 32'h77, 0, 1, 0, 0, 5'd9, 5'd0);
      drive(1, 0, 5'd0, 32'h55, 0, 0, 0, 0, 5'd0, 5'd9);
      idle(4, 5'd0, 5'd9);

      // Stall with three valid entries; the load still fills during the stall.
      drive(1, 0, 5'd1, 32'hA1, 0, 0, 0, 0, 5'd1, 5'd2);
      drive(1, 1, 5'd2, 32'h0, 32'hB2, 0, 0, 0, 5'd1, 5'd2);
      drive(1, 0, 5'd4, 32'hC4, 0, 0, 0, 0, 5'd2, 5'd4);
      drive(1, 0, 5'd6, 32'h66, 0, 0, 1, 0, 5'd2, 5'd1);
      drive(1, 0, 5'd6, 32'h66, 0, 0, 1, 1, 5'd2, 5'd4);
      drive(1, 0, 5'd6, 32'h66, 0, 0, 1, 0, 5'd2, 5'd1);
      drive(1, 0, 5'd6, 32'h66, 0, 0, 1, 0, 5'd2, 5'd4);
      idle(5, 5'd2, 5'd6);

      // Stray load return on an empty buffer, then reset with a load in flight.
      drive(0, 0, 5'd0, 32'h0, 0, 0, 0, 1, 5'd0, 5'd0);
      idle(2, 5'd0, 5'd0);
      drive(1, 1, 5'd10, 32'h0, 32'h1234, 0, 0, 0, 5'd10, 5'd0);
      drive(1, 0, 5'd11, 32'hBB, 0, 0, 0, 0, 5'd10, 5'd11);
      rstn = 1'b0;
      idle(2, 5'd10, 5'd11);
      rstn = 1'b1;
      drive(0, 0, 5'd0, 32'h0, 0, 0, 0, 1, 5'd10, 5'd0);
      idle(2, 5'd10, 5'd0);

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         f = oldest_pend();
         if (f >= 0)
            lsu = ($urandom_range(0, 2) == 0) ||
                  (pipe[DEPTH-1].vld && pipe[DEPTH-1].pend && $urandom_range(0, 1) == 0);
         else
            lsu = ($urandom_range(0, 19) == 0);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
               $urandom(), $urandom(), $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
               lsu, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end

      // Drain: return any outstanding loads and let everything retire.
      for (int c = 0; c < 4 * DEPTH + 4; c++)
         drive(0, 0, 5'd0, 32'h0, 0, 0, 0, oldest_pend() >= 0, 5'($urandom_range(0, 7)), 5'd0);
      check("drain_outstanding_writes", 32'(exp_wr.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
